sonic_dma_burst_reader: RTL and testbench

Drains 128-bit words from the read side of the SONIC circular buffer and turns them into fixed-slot DMA write bursts toward the chaining-DMA engine. It sits directly downstream of the circular buffer, in the read clock domain. It generates host ring addresses with wrap-around and flushes partial bursts after an idle timeout so low-rate traffic is not stranded.

---
 rtl/sonic_dma_pkg.sv | 17 +
 rtl/sonic_skid_buffer.sv | 45 ++++
 rtl/sonic_dma_burst_reader.sv | 155 +++++++++++++++
 tb/tb_sonic_dma_burst_reader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_dma_pkg.sv
// Shared types and constants for the SONIC DMA read path.
package sonic_dma_pkg;

  localparam int unsigned DMA_DATA_W     = 128;
  localparam int unsigned BYTES_PER_WORD = 16;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} state_t;

  typedef enum logic {FULL, FLUSH} mode_t;

  typedef struct packed {
    logic [DMA_DATA_W-1:0] data;
    logic                  sop;
    logic                  eop;
  } dma_beat_t;

endpackage

// File: rtl/sonic_skid_buffer.sv
// Two-entry valid/ready skid buffer for DMA beats; output is a mux of held registers.
module sonic_skid_buffer
  import sonic_dma_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready_c,
  input  dma_beat_t  in_beat,
  output logic       out_valid_c,
  input  logic       out_ready,
  output dma_beat_t  out_beat_c,
  output logic [1:0] count
);

  dma_beat_t mem [2];
  logic      wr_ptr;
  logic      rd_ptr;
  logic      push;
  logic      pop;

  assign in_ready_c  = (count != 2'd2);
  assign out_valid_c = (count != 2'd0);
  assign push        = in_valid & in_ready_c;
  assign pop         = out_valid_c & out_ready;
  assign out_beat_c  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Payload storage needs no reset; occupancy gates its visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_beat;
  end

endmodule

// File: rtl/sonic_dma_burst_reader.sv
// Drains the circular buffer into fixed-slot DMA write bursts with ring
// address wrap and an idle-timeout flush of partial bursts.
module sonic_dma_burst_reader
  import sonic_dma_pkg::*;
#(
  parameter int unsigned DATA_W       = DMA_DATA_W,
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 256
) (
  input  logic              clk_read,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       ring_slots,
  input  logic              empty,
  input  logic              almost_empty,
  input  logic [DATA_W-1:0] data_out,
  output logic              read_enable,
  output logic              dma_valid,
  input  logic              dma_ready,
  output logic [DATA_W-1:0] dma_data,
  output logic              dma_sop,
  output logic              dma_eop,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [8:0]        dma_len,
  output logic              burst_done,
  output logic [31:0]       burst_count
);

  localparam int unsigned CNT_W      = $clog2(BURST_LEN) + 1;
  localparam int unsigned TMR_W      = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned SLOT_BYTES = BURST_LEN * BYTES_PER_WORD;

  state_t           state, state_nx;
  mode_t            mode;
  logic [CNT_W-1:0] reads_issued;
  logic [CNT_W-1:0] beats_sent;
  logic [CNT_W-1:0] pushed;
  logic [TMR_W-1:0] flush_timer;
  logic [15:0]      slot_idx;
  logic [15:0]      ring_lat;
  logic             in_flight;
  logic             start_full;
  logic             start_flush;
  logic             last_c;
  logic             eop_acc;
  logic             skid_valid;
  logic             skid_ready;
  logic [1:0]       skid_count;
  dma_beat_t        push_beat;
  dma_beat_t        head;

  assign push_beat.data = DMA_DATA_W'(data_out);
  assign push_beat.sop  = (pushed == '0);
  assign push_beat.eop  = (pushed + CNT_W'(1) == CNT_W'(BURST_LEN));

  sonic_skid_buffer u_skid (
    .clk         (clk_read),
    .reset       (reset),
    .in_valid    (in_flight),
    .in_ready_c  (skid_ready),
    .in_beat     (push_beat),
    .out_valid_c (skid_valid),
    .out_ready   (dma_ready & dma_valid),
    .out_beat_c  (head),
    .count       (skid_count)
  );

  // The newest issued word is held back during BURST: in flush mode it may
  // turn out to be the eop beat, and eop must not change under a stall.
  assign last_c    = (state == DRAIN) && (beats_sent + CNT_W'(1) == reads_issued);
  assign dma_valid = skid_valid &
                     ((state == DRAIN) ||
                      ((state == BURST) && (beats_sent + CNT_W'(1) < reads_issued)));
  assign dma_data  = DATA_W'(head.data);
  assign dma_sop   = dma_valid & head.sop;
  assign dma_eop   = dma_valid & (head.eop | last_c);
  assign eop_acc   = dma_eop & dma_ready;
  assign dma_len   = 9'(reads_issued);

  // Next state, burst start decode and buffer pop.
  always_comb begin
    state_nx    = state;
    start_full  = 1'b0;
    start_flush = 1'b0;
    read_enable = 1'b0;
    unique case (state)
      IDLE: begin
        start_full  = enable & ~almost_empty;
        start_flush = enable & ~empty & (flush_timer == TMR_W'(FLUSH_CYCLES - 1));
        if (start_full | start_flush) state_nx = BURST;
      end
      BURST: begin
        read_enable = ~empty & (reads_issued < CNT_W'(BURST_LEN)) & skid_ready &
                      ((skid_count + 2'(in_flight)) < 2'd2);
        if ((reads_issued == CNT_W'(BURST_LEN)) ||
            ((mode == FLUSH) && empty && (reads_issued != '0)))
          state_nx = DRAIN;
      end
      DRAIN:   if (eop_acc) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_read) begin
    if (reset) begin
      state        <= IDLE;
      mode         <= FULL;
      reads_issued <= '0;
      beats_sent   <= '0;
      pushed       <= '0;
      flush_timer  <= '0;
      slot_idx     <= 16'd0;
      ring_lat     <= 16'd1;
      in_flight    <= 1'b0;
      dma_addr     <= '0;
      burst_done   <= 1'b0;
      burst_count  <= 32'd0;
    end else begin
      state      <= state_nx;
      in_flight  <= read_enable;
      burst_done <= (state_nx == DONE);
      if (read_enable)             reads_issued <= reads_issued + CNT_W'(1);
      if (in_flight)               pushed       <= pushed + CNT_W'(1);
      if (dma_valid && dma_ready)  beats_sent   <= beats_sent + CNT_W'(1);

      unique case (state)
        IDLE: begin
          if (enable && !empty && almost_empty) begin
            if (flush_timer != TMR_W'(FLUSH_CYCLES - 1)) flush_timer <= flush_timer + TMR_W'(1);
          end else begin
            flush_timer <= '0;
          end
          if (start_full || start_flush) begin
            mode         <= start_full ? FULL : FLUSH;
            dma_addr     <= base_addr + ADDR_W'(slot_idx) * ADDR_W'(SLOT_BYTES);
            ring_lat     <= ring_slots;
            reads_issued <= '0;
            beats_sent   <= '0;
            pushed       <= '0;
          end
        end
        DONE: begin
          burst_count <= burst_count + 32'd1;
          slot_idx    <= (slot_idx + 16'd1 >= ring_lat) ? 16'd0 : slot_idx + 16'd1;
          flush_timer <= '0;
        end
        default: flush_timer <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sonic_dma_burst_reader.sv
// Bench for sonic_dma_burst_reader: behavioural buffer, beat scoreboard and scenario table.
module tb_sonic_dma_burst_reader;
  import sonic_dma_pkg::*;

  localparam int BL = 16;

  logic         clk_read = 1'b0;
  logic         reset;
  logic         enable;
  logic [31:0]  base_addr;
  logic [15:0]  ring_slots;
  logic         empty;
  logic         almost_empty;
  logic [127:0] data_out;
  logic         read_enable;
  logic         dma_valid;
  logic         dma_ready;
  logic [127:0] dma_data;
  logic         dma_sop;
  logic         dma_eop;
  logic [31:0]  dma_addr;
  logic [8:0]   dma_len;
  logic         burst_done;
  logic [31:0]  burst_count;

  always #5 clk_read = ~clk_read;

  sonic_dma_burst_reader dut (
    .clk_read     (clk_read),
    .reset        (reset),
    .enable       (enable),
    .base_addr    (base_addr),
    .ring_slots   (ring_slots),
    .empty        (empty),
    .almost_empty (almost_empty),
    .data_out     (data_out),
    .read_enable  (read_enable),
    .dma_valid    (dma_valid),
    .dma_ready    (dma_ready),
    .dma_data     (dma_data),
    .dma_sop      (dma_sop),
    .dma_eop      (dma_eop),
    .dma_addr     (dma_addr),
    .dma_len      (dma_len),
    .burst_done   (burst_done),
    .burst_count  (burst_count)
  );

  typedef struct {
    int          nwords;
    logic [31:0] base;
    int          ring;
    int          rmode;
    bit          cont;
    int          exp_bursts;
    int          exp_last_len;
    logic [31:0] exp_last_addr;
  } vec_t;

  int applied = 0;
  int miscompares = 0;

  logic [127:0] bufq[$];
  logic [127:0] expq[$];
  int           burst_idx, beat_in_burst, cur_len, done_pulses, last_len;
  logic [31:0]  cur_addr, last_addr, run_base;
  int           run_ring, rmode, cyc, first_re, nre;
  bit           mon_on, re_s, stall_prev;
  logic [127:0] stall_data;
  logic [1:0]   stall_flags;

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkd(string name, logic [127:0] act, logic [127:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic update_flags();
    empty        = (bufq.size() == 0);
    almost_empty = (bufq.size() < BL);
  endtask

  // Scoreboard for one cycle, sampled at the falling edge.
  task automatic monitor();
    logic [127:0] w;
    bit           eop_exp;
    re_s = read_enable;
    if (!mon_on) return;
    if (read_enable) nre++;
    if (read_enable && first_re < 0) first_re = cyc;
    if (burst_done) done_pulses++;
    if (stall_prev) begin
      chk32("hold_valid", 32'(dma_valid), 32'd1);
      chkd("hold_data", dma_data, stall_data);
      chk32("hold_sop_eop", 32'({dma_sop, dma_eop}), 32'(stall_flags));
    end
    stall_prev  = dma_valid && !dma_ready;
    stall_data  = dma_data;
    stall_flags = {dma_sop, dma_eop};
    if (dma_valid && dma_ready) begin
      if (beat_in_burst == 0) begin
        cur_len  = (expq.size() < BL) ? expq.size() : BL;
        cur_addr = run_base + 32'((burst_idx % run_ring) * 256);
        chk32("sop_first", 32'(dma_sop), 32'd1);
        chk32("slot_addr", dma_addr, cur_addr);
      end else begin
        chk32("sop_mid", 32'(dma_sop), 32'd0);
        chk32("addr_hold", dma_addr, cur_addr);
      end
      if (expq.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL extra_beat: got %0h expected none", dma_data);
      end else begin
        w = expq.pop_front();
        chkd("beat_data", dma_data, w);
      end
      eop_exp = (beat_in_burst + 1 == cur_len);
      chk32("eop", 32'(dma_eop), 32'(eop_exp));
      if (eop_exp) begin
        chk32("dma_len", 32'(dma_len), 32'(cur_len));
        last_len  = cur_len;
        last_addr = cur_addr;
        burst_idx++;
        beat_in_burst = 0;
      end else begin
        beat_in_burst++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk_read);
    cyc++;
    monitor();
    @(posedge clk_read);
    #1;
    if (re_s) begin
      if (bufq.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL underflow: got read_enable=1 expected 0 with buffer empty");
      end else begin
        data_out = bufq.pop_front();
      end
    end
    update_flags();
    case (rmode)
      1:       dma_ready = ~dma_ready;
      2:       dma_ready = ($urandom_range(0, 3) != 0);
      default: dma_ready = 1'b1;
    endcase
  endtask

  task automatic clear_model();
    burst_idx     = 0;
    beat_in_burst = 0;
    done_pulses   = 0;
    stall_prev    = 1'b0;
    nre           = 0;
  endtask

  task automatic do_reset();
    mon_on    = 1'b0;
    reset     = 1'b1;
    enable    = 1'b0;
    rmode     = 0;
    dma_ready = 1'b1;
    data_out  = '0;
    bufq.delete();
    expq.delete();
    update_flags();
    tick();
    tick();
    reset = 1'b0;
    clear_model();
    mon_on = 1'b1;
  endtask

  task automatic preload(int n);
    logic [127:0] w;
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      bufq.push_back(w);
      expq.push_back(w);
    end
    update_flags();
  endtask

  task automatic run_vec(vec_t v);
    if (!v.cont) do_reset();
    base_addr  = v.base;
    ring_slots = 16'(v.ring);
    run_base   = v.base;
    run_ring   = v.ring;
    rmode      = v.rmode;
    enable     = 1'b1;
    preload(v.nwords);
    first_re = -1;
    cyc      = 0;
    while (burst_idx < v.exp_bursts && cyc < 4000) tick();
    if (burst_idx < v.exp_bursts) begin
      applied++;
      miscompares++;
      $display("FAIL timeout: got %0d bursts expected %0d", burst_idx, v.exp_bursts);
    end
    for (int i = 0; i < 3; i++) tick();
    chk32("burst_count", burst_count, 32'(v.exp_bursts));
    chk32("burst_done_pulses", 32'(done_pulses), 32'(v.exp_bursts));
    chk32("last_len", 32'(last_len), 32'(v.exp_last_len));
    chk32("last_addr", last_addr, v.exp_last_addr);
    chk32("words_left", 32'(expq.size()), 32'd0);
    if (v.nwords < BL && !v.cont) begin
      chk32("flush_wait_min", 32'(first_re >= 255), 32'd1);
      chk32("flush_wait_max", 32'(first_re <= 262), 32'd1);
    end
  endtask

  vec_t vecs[7];
  vec_t rv;

  initial begin
    vecs[0] = '{32, 32'h1000, 4, 0, 1'b0, 2, 16, 32'h1100};
    vecs[1] = '{16, 32'h2000, 4, 1, 1'b0, 1, 16, 32'h2000};
    vecs[2] = '{3,  32'h1000, 4, 0, 1'b0, 1, 3,  32'h1000};
    vecs[3] = '{16, 32'h1000, 4, 0, 1'b1, 2, 16, 32'h1100};
    vecs[4] = '{48, 32'h4000, 2, 0, 1'b0, 3, 16, 32'h4000};
    vecs[5] = '{19, 32'h8000, 3, 2, 1'b0, 2, 3,  32'h8100};
    vecs[6] = '{1,  32'h0,    4, 2, 1'b0, 1, 1,  32'h0};

    base_addr  = '0;
    ring_slots = 16'd1;
    do_reset();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Randomized sizes, ring depths and backpressure against an arithmetic model.
    for (int k = 0; k < 4; k++) begin
      rv.nwords        = $urandom_range(1, 50);
      rv.base          = $urandom & 32'hFFFF_FFF0;
      rv.ring          = $urandom_range(1, 4);
      rv.rmode         = 2;
      rv.cont          = 1'b0;
      rv.exp_bursts    = (rv.nwords + BL - 1) / BL;
      rv.exp_last_len  = (rv.nwords % BL == 0) ? BL : rv.nwords % BL;
      rv.exp_last_addr = rv.base + 32'(((rv.exp_bursts - 1) % rv.ring) * 256);
      run_vec(rv);
    end

    // Reset on beat 5 of a burst, then a fresh burst from slot 0.
    do_reset();
    base_addr  = 32'h3000;
    ring_slots = 16'd4;
    run_base   = 32'h3000;
    run_ring   = 4;
    enable     = 1'b1;
    preload(32);
    cyc = 0;
    while (!(burst_idx == 0 && beat_in_burst == 5) && cyc < 500) tick();
    chk32("reached_beat5", 32'(beat_in_burst), 32'd5);
    mon_on = 1'b0;
    reset  = 1'b1;
    tick();
    chk32("rst_read_enable", 32'(read_enable), 32'd0);
    chk32("rst_dma_valid", 32'(dma_valid), 32'd0);
    chk32("rst_dma_sop", 32'(dma_sop), 32'd0);
    chk32("rst_dma_eop", 32'(dma_eop), 32'd0);
    chk32("rst_dma_addr", dma_addr, 32'd0);
    chk32("rst_dma_len", 32'(dma_len), 32'd0);
    chk32("rst_burst_done", 32'(burst_done), 32'd0);
    chk32("rst_burst_count", burst_count, 32'd0);
    reset = 1'b0;
    bufq.delete();
    expq.delete();
    update_flags();
    clear_model();
    mon_on = 1'b1;
    preload(16);
    cyc = 0;
    while (burst_idx < 1 && cyc < 500) tick();
    for (int i = 0; i < 3; i++) tick();
    chk32("post_rst_addr", last_addr, 32'h3000);
    chk32("post_rst_count", burst_count, 32'd1);

    // Single-word flush with enable dropped mid-burst; IDLE must then hold.
    do_reset();
    base_addr  = 32'h5000;
    ring_slots = 16'd4;
    run_base   = 32'h5000;
    run_ring   = 4;
    enable     = 1'b1;
    preload(1);
    first_re = -1;
    cyc      = 0;
    while (first_re < 0 && cyc < 400) tick();
    enable = 1'b0;
    cyc    = 0;
    while (burst_idx < 1 && cyc < 100) tick();
    chk32("single_len", 32'(last_len), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk32("single_count", burst_count, 32'd1);
    for (int i = 0; i < 20; i++) bufq.push_back(128'(i));
    update_flags();
    nre = 0;
    for (int i = 0; i < 300; i++) tick();
    chk32("disabled_reads", 32'(nre), 32'd0);
    chk32("disabled_count", burst_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
